// File: rtl/router_wr_ctrl.sv
// Router write-side controller: decodes packet headers, steers header/payload/parity
// bytes into one of three destination FIFOs, checks parity and drops malformed packets.
module router_wr_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  output logic       busy,
  output logic       err,
  output logic [2:0] write_enb,
  output logic [7:0] fifo_din
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitEmpty,
    StLoadData,
    StLoadParity,
    StCheck,
    StDrop
  } state_e;

  state_e     r_state;
  logic [7:0] r_hdr;
  logic [5:0] r_cnt;
  logic [6:0] r_drop;
  logic [7:0] r_parity;
  logic       r_mismatch;

  logic [1:0] w_dest_in;
  logic [5:0] w_len_in;
  logic [1:0] w_dest_q;
  logic [3:0] w_full4;
  logic [3:0] w_empty4;
  logic       w_hdr_drop;
  logic       w_busy;
  logic       w_accept_state;
  logic       w_accept;
  logic       w_write;
  logic [1:0] w_dest;

  assign w_dest_in  = data_in[1:0];
  assign w_len_in   = data_in[7:2];
  assign w_dest_q   = r_hdr[1:0];
  // Pad to four entries so a dest of 3 indexes a constant 0 instead of going out of range.
  assign w_full4    = {1'b0, fifo_full};
  assign w_empty4   = {1'b0, fifo_empty};
  assign w_hdr_drop = (w_dest_in == 2'd3) || (w_len_in == 6'd0);

  always_comb begin
    w_busy         = 1'b0;
    w_accept_state = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy         = 1'b0;
        w_accept_state = 1'b1;
      end
      StWaitEmpty: w_busy = 1'b1;
      StLoadData, StLoadParity: begin
        w_busy         = w_full4[w_dest_q];
        w_accept_state = 1'b1;
      end
      StCheck: w_busy = 1'b1;
      StDrop: begin
        w_busy         = 1'b0;
        w_accept_state = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  assign w_accept = pkt_valid & ~w_busy & w_accept_state;

  always_comb begin
    w_write = 1'b0;
    w_dest  = w_dest_q;
    unique case (r_state)
      StIdle: begin
        w_write = w_accept & ~w_hdr_drop & w_empty4[w_dest_in];
        w_dest  = w_dest_in;
      end
      StWaitEmpty:              w_write = w_empty4[w_dest_q];
      StLoadData, StLoadParity: w_write = w_accept;
      default:                  w_write = 1'b0;
    endcase
  end

  // Reset masks outputs combinationally because the state only clears on the next edge.
  assign busy      = w_busy & ~reset;
  assign err       = (r_state == StCheck) & r_mismatch & ~reset;
  assign write_enb = (w_write & ~reset) ? (3'b001 << w_dest) : 3'b000;
  assign fifo_din  = (r_state == StWaitEmpty) ? r_hdr : data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_hdr      <= 8'h00;
      r_cnt      <= 6'd0;
      r_drop     <= 7'd0;
      r_parity   <= 8'h00;
      r_mismatch <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_hdr      <= data_in;
            r_parity   <= data_in;
            r_cnt      <= w_len_in;
            r_mismatch <= 1'b0;
            if (w_hdr_drop) begin
              r_drop  <= {1'b0, w_len_in} + 7'd1;
              r_state <= StDrop;
            end else if (w_empty4[w_dest_in]) begin
              r_state <= StLoadData;
            end else begin
              r_state <= StWaitEmpty;
            end
          end
        end
        StWaitEmpty: begin
          if (w_empty4[w_dest_q]) r_state <= StLoadData;
        end
        StLoadData: begin
          if (w_accept) begin
            r_parity <= r_parity ^ data_in;
            r_cnt    <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) r_state <= StLoadParity;
          end
        end
        StLoadParity: begin
          if (w_accept) begin
            r_mismatch <= (data_in != r_parity);
            r_state    <= StCheck;
          end
        end
        StCheck: begin
          r_mismatch <= 1'b0;
          r_state    <= StIdle;
        end
        StDrop: begin
          if (w_accept) begin
            r_drop <= r_drop - 7'd1;
            if (r_drop == 7'd1) begin
              r_mismatch <= 1'b1;
              r_state    <= StCheck;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
